// File: rtl/run_detect_pkg.sv
// -----------------------------------------------------------------------------
// run_detect_pkg
//   Shared constants and helpers for the run-length detector / scheduler slice.
//
//   Contents
//     NCH_DEF, THRESH_DEF, MAXRUN_DEF : default parameter values
//     idx_w(n)                        : width of an index into n items (>= 1)
//
//   Optional feature (see run_detect_sched): RUN_DETECT_STICKY_STATUS_EN
// -----------------------------------------------------------------------------
package run_detect_pkg;

  localparam int NCH_DEF    = 4;
  localparam int THRESH_DEF = 2;
  localparam int MAXRUN_DEF = 15;

  // Index width for n items; never collapses to zero so that a 1-bit
  // index is still produced for the minimum two-channel configuration.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/run_detect_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin single-grant arbiter. The search starts one past the last
//   accepted index and wraps from NCH-1 to 0. The grant is purely
//   combinational from valid and the pointer; the pointer only moves when
//   the caller reports that the granted transfer was accepted.
//
//   Ports
//     clk       : clock, rising edge
//     rst       : asynchronous, active-low reset (pointer -> NCH-1)
//     valid     : NCH request lines
//     accept    : a transfer on the current grant completes this cycle
//     grant     : one-hot grant (all zero when no request)
//     grant_idx : binary index of the granted line (0 when none)
//     ptr       : last accepted index, exposed for observation
// -----------------------------------------------------------------------------
module rr_arbiter
  import run_detect_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  localparam int CHW = idx_w(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] valid,
  input  logic           accept,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] grant_idx,
  output logic [CHW-1:0] ptr
);

  // One extra bit so ptr + k (k <= NCH) never overflows before the wrap.
  logic [CHW:0]   sum;
  logic [CHW-1:0] cand;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      sum = {1'b0, ptr} + (CHW+1)'(k);
      if (sum >= (CHW+1)'(NCH)) begin
        sum = sum - (CHW+1)'(NCH);
      end
      cand = sum[CHW-1:0];
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer at NCH-1 after reset makes channel 0 the first one served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= CHW'(NCH - 1);
    end else if (accept) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/run_detect_sched.sv
// -----------------------------------------------------------------------------
// run_detect_sched
//   Schedules NCH serial bit streams onto a single detector. One channel is
//   served per cycle (round robin). Each channel keeps its own count of
//   consecutive ones, saturating at MAXRUN. Whenever a served one brings the
//   count to THRESH or above, a one-cycle detection pulse reports the
//   channel and the run length.
//
//   Handshake: channel i transfers a bit on a rising edge where
//   req_valid[i] && req_ready[i]. req_ready is one-hot (or zero), computed
//   combinationally from req_valid; a requester holds req_valid/req_bit
//   until granted. At most one transfer happens per cycle.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous, active-low reset
//     req_valid  : [NCH]  channel presents a bit
//     req_bit    : [NCH]  serial data bit of each channel
//     req_ready  : [NCH]  one-hot grant
//     det_valid  : detection pulse, one cycle after the qualifying transfer
//     det_ch     : channel of the last detection (held between detections)
//     det_run    : run length of the last detection (held)
//     clr_status : [NCH]  clear sticky flags   (RUN_DETECT_STICKY_STATUS_EN)
//     status     : [NCH]  sticky detection flags (RUN_DETECT_STICKY_STATUS_EN)
//
//   Build option: define RUN_DETECT_STICKY_STATUS_EN to add the sticky
//   per-channel status register and its two ports.
// -----------------------------------------------------------------------------
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter  int NCH    = NCH_DEF,
  parameter  int THRESH = THRESH_DEF,
  parameter  int MAXRUN = MAXRUN_DEF,
  localparam int CHW    = idx_w(NCH),
  localparam int CW     = $clog2(MAXRUN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_valid,
  input  logic [NCH-1:0] req_bit,
  output logic [NCH-1:0] req_ready,
  output logic           det_valid,
  output logic [CHW-1:0] det_ch,
  output logic [CW-1:0]  det_run
`ifdef RUN_DETECT_STICKY_STATUS_EN
  ,
  input  logic [NCH-1:0] clr_status,
  output logic [NCH-1:0] status
`endif
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [CHW-1:0] gidx;
  logic [CHW-1:0] rr_ptr;
  logic           xfer;

  // The grant is a subset of req_valid, so any grant is a transfer.
  assign xfer = |(req_valid & req_ready);

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .accept    (xfer),
    .grant     (req_ready),
    .grant_idx (gidx),
    .ptr       (rr_ptr)
  );

  // ---------------------------------------------------------------------------
  // Per-channel run counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] run [NCH];
  logic [CW-1:0] cur_run;
  logic [CW-1:0] next_run;
  logic          bit_in;
  logic          det_now;

  always_comb begin
    cur_run  = run[gidx];
    bit_in   = req_bit[gidx];
    next_run = '0;
    if (bit_in) begin
      // Saturate rather than wrap so long runs keep reporting MAXRUN.
      if (cur_run == CW'(MAXRUN)) begin
        next_run = CW'(MAXRUN);
      end else begin
        next_run = cur_run + 1'b1;
      end
    end
    // Detection fires on every qualifying one, including while saturated.
    det_now = xfer && bit_in && (next_run >= CW'(THRESH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        run[c] <= '0;
      end
    end else if (xfer) begin
      run[gidx] <= next_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Detection output: pulse for one cycle, channel/run held until the next hit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_valid <= 1'b0;
      det_ch    <= '0;
      det_run   <= '0;
    end else begin
      det_valid <= det_now;
      if (det_now) begin
        det_ch  <= gidx;
        det_run <= next_run;
      end
    end
  end

`ifdef RUN_DETECT_STICKY_STATUS_EN
  // ---------------------------------------------------------------------------
  // Sticky status: set on a detection in the transfer cycle, so it becomes
  // visible together with det_valid. Set wins over a coincident clear.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] det_set;

  always_comb begin
    det_set = '0;
    if (det_now) begin
      det_set[gidx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status <= '0;
    end else begin
      status <= (status & ~clr_status) | det_set;
    end
  end
`endif

endmodule

// File: doc/run_detect_sched.md
RUN_DETECT_SCHED -- requirements
Module: run_detect_sched

Interface
REQ-001 SHALL have parameter NCH, default 4: number of serial requester channels, range 2..8.
REQ-002 SHALL have parameter THRESH, default 2: consecutive-ones count at which detection starts, range 1..MAXRUN.
REQ-003 SHALL have parameter MAXRUN, default 15: saturation value of the per-channel run counter; CW = clog2(MAXRUN+1).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NCH: channel i presents a bit.
REQ-007 SHALL have port req_bit, input, NCH: serial data bit of channel i.
REQ-008 SHALL have port req_ready, output, NCH: one-hot grant; a transfer occurs on channel i when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port det_valid, output, 1: one-cycle detection pulse.
REQ-010 SHALL have port det_ch, output, clog2(NCH): channel of the detection.
REQ-011 SHALL have port det_run, output, CW: run length at the detection.
REQ-012 SHALL have port clr_status, input, NCH: clear sticky status bits (only with STICKY_STATUS_EN).
REQ-013 SHALL have port status, output, NCH: sticky per-channel detection flags (only with STICKY_STATUS_EN).

Function
REQ-014 SHALL compute req_ready combinationally from req_valid and rr_ptr: the first valid channel searched from rr_ptr+1 upward, wrapping NCH-1 to 0; all zero when no channel is valid.
REQ-015 SHALL load rr_ptr with the granted index only on a transfer; rr_ptr SHALL hold in idle cycles.
REQ-016 SHALL accept at most one transfer per cycle; requesters hold req_valid/req_bit until granted.
REQ-017 On a transfer with bit 0, SHALL set run[c] to 0.
REQ-018 On a transfer with bit 1, SHALL set run[c] to min(run[c]+1, MAXRUN); saturation SHALL hold MAXRUN, never wrap.
REQ-019 SHALL leave run[] of non-granted channels unchanged.
REQ-020 SHALL assert det_valid exactly one cycle after a transfer with bit 1 and new run[c] >= THRESH; det_valid SHALL fire on every such transfer, including while saturated.
REQ-021 SHALL register det_ch and det_run on every detection and hold them between detections.
REQ-022 SHALL deassert det_valid in any cycle following a cycle without a qualifying transfer.

Reset
REQ-023 While rst is low, SHALL force run[] = 0, rr_ptr = NCH-1 (channel 0 served first), det_valid = 0, det_ch = 0, det_run = 0 and status = 0, independent of clk.
REQ-024 SHALL drop a transfer coincident with reset assertion, with no detection after release.
REQ-025 SHALL still drive req_ready combinationally during reset; transfers during reset SHALL have no effect.

Configuration
REQ-026 SHALL compile, with macro RUN_DETECT_STICKY_STATUS_EN defined, a per-channel sticky register: status[c] set on a detection for c, cleared by clr_status[c]; coincident set and clear SHALL leave it set.
REQ-027 Without RUN_DETECT_STICKY_STATUS_EN, SHALL omit the clr_status and status ports and the register entirely.

Structure
REQ-028 SHALL take default NCH, THRESH and MAXRUN constants and the index-width helper from shared package run_detect_pkg.
REQ-029 SHALL put the round-robin search and pointer in one sub-module, rr_arbiter (NCH-wide valid in, one-hot grant out, pointer update on accept); run counters and detection stay in the top.

Verification
REQ-030 SHALL be verified with: reset release, ch0 sends bits 1,1,1,0 -> det_valid on cycles after the 2nd and 3rd bits with det_run 2 then 3; none after the 0.
REQ-031 SHALL be verified with: all four channels valid continuously -> grants 0,1,2,3,0 in successive cycles.
REQ-032 SHALL be verified with: ch2 sends 17 ones (MAXRUN 15) -> det_run 2..15, then 15 twice, with det_valid on every bit from the 2nd.
REQ-033 SHALL be verified with: ch1 sends 1, ch3 sends 1,1 interleaved, then ch1 sends 1 -> ch1 detects with run 2, showing per-channel state survives interleaving.
REQ-034 SHALL be verified with: rst pulsed low mid-run on ch0 (run 3) -> outputs 0 immediately; next single 1 on ch0 gives no detection.
REQ-035 SHALL be verified with, under RUN_DETECT_STICKY_STATUS_EN: detection on ch1 and clr_status[1] in the same cycle -> status[1] = 1; clr alone next cycle -> 0.
